lcg_stim_gen: RTL and testbench
===============================

LCG_STIM_GEN -- requirements
Module: lcg_stim_gen

Interface
REQ-001 The module SHALL have parameter WIDTH, default 141, meaning the stimulus vector width in bits (legal range 1..1024).
REQ-002 The module SHALL have parameter SEED, default 1806341205, meaning the 32-bit LCG state value after reset.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port start, input, 1 bit: single-cycle request to begin a run.
REQ-006 The module SHALL have port seed_load, input, 1 bit: load seed_in into the LCG state.
REQ-007 The module SHALL have port seed_in, input, 32 bits: seed value.
REQ-008 The module SHALL have port cycles_in, input, 32 bits: number of vectors after the initial vector.
REQ-009 The module SHALL have port out_valid, output, 1 bit: out_data holds a complete vector.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the vector.
REQ-011 The module SHALL have port out_data, output, WIDTH bits: the stimulus vector.
REQ-012 The module SHALL have port vec_idx, output, 32 bits: index of the vector currently presented.
REQ-013 The module SHALL have ports busy and done, output, 1 bit each: run in progress, and run complete.

Function
REQ-014 The LCG step SHALL be state = (state * 0x41C64E6D + 0x3039) mod 2^32.
REQ-015 The LCG SHALL step once per word; NW = ceil(WIDTH/32) words SHALL make up one vector.
REQ-016 Word k SHALL fill out_data[32k+31:32k]; the last word SHALL use only its low WIDTH-32(NW-1) state bits.
REQ-017 The FSM SHALL have the states IDLE, FILL, PRESENT and DONE.
REQ-018 IDLE -> FILL SHALL occur on start; cycles_in SHALL be latched at that point and vec_idx cleared.
REQ-019 FILL SHALL generate one word per clock; after NW clocks the FSM SHALL enter PRESENT with out_valid=1.
REQ-020 In PRESENT, out_data and vec_idx SHALL stay stable while out_ready=0.
REQ-021 A transfer SHALL be out_valid and out_ready in the same cycle; vec_idx SHALL then increment.
REQ-022 After a transfer, the FSM SHALL return to FILL if vec_idx < latched cycles; otherwise it SHALL go to DONE.
REQ-023 A run SHALL emit exactly cycles+1 vectors; cycles=0 SHALL emit exactly one vector.
REQ-024 In DONE, done=1 and out_valid=0; start SHALL begin a new run whose LCG state continues unbroken.
REQ-025 busy SHALL be 1 in FILL and PRESENT only.
REQ-026 start and seed_load SHALL be ignored while busy=1.
REQ-027 When seed_load and start are both asserted in IDLE or DONE, the loaded seed SHALL be used by the new run: the first word generated SHALL be LCG(seed_in).
REQ-028 seed_load alone in IDLE or DONE SHALL load the state without changing the FSM state.
REQ-029 vec_idx SHALL wrap modulo 2^32; cycles_in=0xFFFFFFFF SHALL NOT terminate early.

Reset
REQ-030 While rst=1, the module SHALL hold: FSM=IDLE, LCG state=SEED, out_valid=0, out_data=0, vec_idx=0, busy=0, done=0.
REQ-031 Assertion of rst mid-run SHALL abort the run immediately and discard any partial vector.
REQ-032 After rst is released, the first start SHALL reproduce the post-reset sequence bit-exactly.

Configuration
REQ-033 Macro LCG_STIM_PREFETCH_EN SHALL select the prefetch feature.
REQ-034 With LCG_STIM_PREFETCH_EN defined, a second vector buffer SHALL fill during PRESENT.
- With out_ready held at 1, vectors SHALL be produced back-to-back, one per clock, after the first.
- The emitted values SHALL be identical to those without the macro.
REQ-035 Without LCG_STIM_PREFETCH_EN, there SHALL be a single buffer and NW FILL clocks between consecutive vectors.

Verification
REQ-036 The bench SHALL cover: seed_load with seed_in=0, then start with cycles_in=0 -> out_data[31:0]=0x00003039, out_data[63:32]=0xD3DC167E, exactly one transfer, then done=1.
REQ-037 The bench SHALL cover: reset then start with cycles_in=100, out_ready=1 -> 101 transfers; vec_idx runs 0..100; busy falls when done rises.
REQ-038 The bench SHALL cover: out_ready held low for 20 clocks in PRESENT -> out_data and vec_idx unchanged; the transfer completes on the first clock with out_ready=1.
REQ-039 The bench SHALL cover: rst pulsed during FILL of vector 3 -> outputs return to their reset values; a rerun matches the original sequence from vector 0.
REQ-040 The bench SHALL cover: start and seed_load asserted while busy -> no effect on the data stream or on vec_idx.
REQ-041 The bench SHALL cover: WIDTH=141 with LCG_STIM_PREFETCH_EN defined and out_ready=1 -> vector spacing of 1 clock with data equal to the build without the macro, whose spacing is 5 FILL clocks plus the transfer clock.

Source files
------------

// File: rtl/lcg_stim_gen.sv
// rtl/lcg_stim_gen.sv - LCG-based stimulus vector generator with valid/ready output
// Optional prefetch buffer selected by `define LCG_STIM_PREFETCH_EN.
module lcg_stim_gen #(
    parameter int          WIDTH = 141,
    parameter logic [31:0] SEED  = 32'd1806341205
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             seed_load,
    input  logic [31:0]      seed_in,
    input  logic [31:0]      cycles_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [31:0]      vec_idx,
    output logic             busy,
    output logic             done
);
    localparam int NW = (WIDTH + 31) / 32;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {IDLE, FILL, PRESENT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      lcg;
    logic [31:0]      lcg_nxt;
    logic [CW-1:0]    word_cnt;
    logic [WIDTH-1:0] vec_buf;
    logic [31:0]      cycles_lat;
    logic             word_last;
    logic             more_vec;

    function automatic logic [31:0] lcg_step(input logic [31:0] s);
        return s * 32'h41C64E6D + 32'h0000_3039;
    endfunction

    assign lcg_nxt   = lcg_step(lcg);
    assign word_last = (word_cnt == CW'(NW - 1));
    assign more_vec  = (vec_idx < cycles_lat);
    assign out_data  = vec_buf;

`ifdef LCG_STIM_PREFETCH_EN
    logic [31:0]      chain_words [NW];
    logic [WIDTH-1:0] chain_vec;
    logic [WIDTH-1:0] pf_buf;
    logic             pf_valid;
    logic [32:0]      pf_target;
    logic             pf_gen_ok;

    // A whole vector is stepped out in one clock so the spare buffer keeps up with the consumer.
    always_comb begin
        chain_words[0] = lcg_nxt;
        for (int k = 1; k < NW; k++) begin
            chain_words[k] = lcg_step(chain_words[k-1]);
        end
        chain_vec = '0;
        for (int b = 0; b < WIDTH; b++) begin
            chain_vec[b] = chain_words[b / 32][b % 32];
        end
    end

    // Never generate past the last vector of the run, so the LCG state matches the single-buffer build.
    assign pf_target = {1'b0, vec_idx} + (pf_valid ? 33'd2 : 33'd1);
    assign pf_gen_ok = (pf_target <= {1'b0, cycles_lat});
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = FILL;
            end
            FILL: begin
                busy = 1'b1;
                if (word_last) state_nxt = PRESENT;
            end
            PRESENT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
`ifdef LCG_STIM_PREFETCH_EN
                    state_nxt = more_vec ? PRESENT : DONE;
`else
                    state_nxt = more_vec ? FILL : DONE;
`endif
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = FILL;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcg        <= SEED;
            word_cnt   <= '0;
            vec_buf    <= '0;
            cycles_lat <= '0;
            vec_idx    <= '0;
`ifdef LCG_STIM_PREFETCH_EN
            pf_buf     <= '0;
            pf_valid   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (seed_load) lcg <= seed_in;
                    if (start) begin
                        cycles_lat <= cycles_in;
                        vec_idx    <= '0;
                        word_cnt   <= '0;
`ifdef LCG_STIM_PREFETCH_EN
                        pf_valid   <= 1'b0;
`endif
                    end
                end
                FILL: begin
                    lcg <= lcg_nxt;
                    for (int b = 0; b < WIDTH; b++) begin
                        if (b / 32 == int'(word_cnt)) vec_buf[b] <= lcg_nxt[b % 32];
                    end
                    word_cnt <= word_last ? '0 : word_cnt + 1'b1;
                end
                PRESENT: begin
`ifdef LCG_STIM_PREFETCH_EN
                    if (out_ready) begin
                        vec_idx <= vec_idx + 32'd1;
                        if (pf_valid) begin
                            vec_buf <= pf_buf;
                            if (pf_gen_ok) begin
                                pf_buf <= chain_vec;
                                lcg    <= chain_words[NW-1];
                            end else begin
                                pf_valid <= 1'b0;
                            end
                        end else if (pf_gen_ok) begin
                            vec_buf <= chain_vec;
                            lcg     <= chain_words[NW-1];
                        end
                    end else if (!pf_valid && pf_gen_ok) begin
                        pf_buf   <= chain_vec;
                        pf_valid <= 1'b1;
                        lcg      <= chain_words[NW-1];
                    end
`else
                    if (out_ready) vec_idx <= vec_idx + 32'd1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb/tb_lcg_stim_gen.sv - randomized self-checking bench for lcg_stim_gen
// Reference model regenerates each vector from the LCG recurrence in 64-bit arithmetic.
module tb_lcg_stim_gen;
    localparam int          WIDTH = 141;
    localparam int          NW    = (WIDTH + 31) / 32;
    localparam logic [31:0] SEED  = 32'd1806341205;
`ifdef LCG_STIM_PREFETCH_EN
    localparam int GAP = 1;
`else
    localparam int GAP = NW + 1;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic             seed_load;
    logic [31:0]      seed_in;
    logic [31:0]      cycles_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [31:0]      vec_idx;
    logic             busy;
    logic             done;

    int               n_checks;
    int               n_errors;
    logic [31:0]      m_state;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] vec0;

    lcg_stim_gen #(.WIDTH(WIDTH), .SEED(SEED)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .cycles_in (cycles_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_vec();
        logic [NW*32-1:0] full;
        logic [63:0]      acc;
        full = '0;
        for (int k = 0; k < NW; k++) begin
            acc     = (64'(m_state) * 64'd1103515245 + 64'd12345) % 64'h1_0000_0000;
            m_state = acc[31:0];
            full[k*32 +: 32] = m_state;
        end
        return full[WIDTH-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("rst_valid", WIDTH'(out_valid), '0);
        check("rst_data", out_data, '0);
        check("rst_idx", WIDTH'(vec_idx), '0);
        check("rst_busy", WIDTH'(busy), '0);
        check("rst_done", WIDTH'(done), '0);
        rst     = 1'b0;
        m_state = SEED;
    endtask

    task automatic seed_only(input logic [31:0] seed);
        seed_load = 1'b1;
        seed_in   = seed;
        tick();
        seed_load = 1'b0;
        m_state   = seed;
        check("seed_only_busy", WIDTH'(busy), '0);
        check("seed_only_valid", WIDTH'(out_valid), '0);
    endtask

    // mode 0: always ready (spacing checked), 1: random ready, 2: random ready plus pokes while busy,
    // 3: first vector stalled 20 clocks
    task automatic run(input logic [31:0] cyc, input int mode, input bit do_seed, input logic [31:0] seed);
        int n_xfer;
        int last_t;
        int stall;
        logic rdy;
        exp_q.delete();
        if (do_seed) m_state = seed;
        for (int i = 0; i <= int'(cyc); i++) exp_q.push_back(model_vec());
        start     = 1'b1;
        seed_load = do_seed;
        seed_in   = seed;
        cycles_in = cyc;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
        seed_in   = $urandom;
        cycles_in = $urandom;
        n_xfer    = 0;
        last_t    = 0;
        stall     = 0;
        for (int t = 0; t < 20000 && n_xfer <= int'(cyc); t++) begin
            start     = 1'b0;
            seed_load = 1'b0;
            rdy       = 1'b0;
            check("busy", WIDTH'(busy), WIDTH'(1));
            check("idx", WIDTH'(vec_idx), WIDTH'(n_xfer));
            if (out_valid) begin
                check("data", out_data, exp_q[n_xfer]);
                if (n_xfer == 0) vec0 = out_data;
                case (mode)
                    0: rdy = 1'b1;
                    3: begin
                        if (n_xfer == 0 && stall < 20) begin
                            stall++;
                        end else begin
                            rdy = 1'b1;
                        end
                    end
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                if (rdy) begin
                    if (mode == 0 && n_xfer > 0) check("gap", WIDTH'(t - last_t), WIDTH'(GAP));
                    last_t = t;
                    n_xfer++;
                end
            end
            out_ready = rdy;
            if (mode == 2 && busy && $urandom_range(0, 3) == 0) begin
                start     = 1'b1;
                seed_load = 1'b1;
                seed_in   = $urandom;
                cycles_in = $urandom;
            end
            tick();
        end
        start     = 1'b0;
        seed_load = 1'b0;
        out_ready = 1'b0;
        check("xfers", WIDTH'(n_xfer), WIDTH'(int'(cyc) + 1));
        if (mode == 3) check("stall_len", WIDTH'(stall), WIDTH'(20));
        check("end_done", WIDTH'(done), WIDTH'(1));
        check("end_busy", WIDTH'(busy), '0);
        check("end_valid", WIDTH'(out_valid), '0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        seed_load = 1'b0;
        seed_in   = '0;
        cycles_in = '0;
        out_ready = 1'b0;
        m_state   = SEED;
        tick();
        do_reset();

        seed_only(32'd0);
        run(32'd0, 1, 1'b0, 32'd0);
        check("zero_seed_w0", WIDTH'(vec0[31:0]), WIDTH'(32'h0000_3039));
        check("zero_seed_w1", WIDTH'(vec0[63:32]), WIDTH'(32'hD3DC_167E));

        do_reset();
        run(32'd100, 0, 1'b0, 32'd0);
        run(32'd5, 1, 1'b0, 32'd0);
        run(32'd2, 3, 1'b0, 32'd0);
        run(32'd8, 2, 1'b0, 32'd0);
        run(32'd3, 1, 1'b1, $urandom);
        seed_only($urandom);
        run(32'd2, 1, 1'b0, 32'd0);

        do_reset();
        start     = 1'b1;
        cycles_in = 32'd10;
        tick();
        start     = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (busy && vec_idx == 32'd3) break;
            tick();
        end
        check("reach_vec3", WIDTH'(vec_idx), WIDTH'(3));
        out_ready = 1'b0;
        do_reset();
        run(32'd10, 0, 1'b0, 32'd0);

        for (int i = 0; i < 4; i++) begin
            run(32'($urandom_range(0, 6)), 1 + (i % 2), 1'(i == 2), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
